// File: rtl/intr_controller.sv
// Interrupt sequencer: accepts a masked irq, drains the pipeline, saves the
// interrupted PC into EPC through the register-file write port, then redirects
// fetch to the per-cause vector and blocks further interrupts until return.
//
// Ports:
//   clk, rst            clock / async active-high reset
//   irq                 level-sensitive requests
//   irq_en_wr/_data     enable-mask load
//   data_hazard         ID stalled; do not accept this cycle
//   intr_return         handler return decoded in ID
//   pc_id               PC of the instruction in ID (saved as EPC)
//   wb_*                WB write request (passed to RegWrite_* outputs)
//   RegWrite_*_out      register-file write port
//   flush               squash IF/ID and ID/EX
//   pc_redirect(_addr)  one-cycle fetch redirect to the vector
//   intr_active/_cause  handler status
//   irq_en              current enable mask
module intr_controller #(
  parameter int          NUM_IRQ      = 4,
  parameter logic [31:0] VEC_BASE     = 32'h0000_0100,
  parameter int          VEC_STRIDE   = 4,
  parameter int          DRAIN_CYCLES = 3,
  parameter logic [4:0]  EPC_REG      = 5'h1E
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               irq_en_wr,
  input  logic [NUM_IRQ-1:0] irq_en_data,
  input  logic               data_hazard,
  input  logic               intr_return,
  input  logic [31:0]        pc_id,
  input  logic               wb_regwrite,
  input  logic [4:0]         wb_reg,
  input  logic [31:0]        wb_data,
  output logic               RegWrite_out,
  output logic [4:0]         RegWrite_Reg_out,
  output logic [31:0]        RegWrite_Data_out,
  output logic               flush,
  output logic               pc_redirect,
  output logic [31:0]        pc_redirect_addr,
  output logic               intr_active,
  output logic [2:0]         intr_cause,
  output logic [NUM_IRQ-1:0] irq_en
);

  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE, DRAIN, SAVE, VECTOR, HANDLER
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic [31:0]        r_epc;
  logic [2:0]         r_cause;
  logic [NUM_IRQ-1:0] r_irq_en;
  logic [NUM_IRQ-1:0] w_pend;
  logic [2:0]         w_win;
  logic               w_accept;

  assign w_pend   = irq & r_irq_en;
  assign w_accept = (r_state == IDLE) && (|w_pend) && !data_hazard;
  assign irq_en   = r_irq_en;

  // Lowest set index wins: scan downward so the last hit is the lowest.
  always_comb begin
    w_win = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_pend[i]) w_win = 3'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_epc    <= '0;
      r_cause  <= '0;
      r_irq_en <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (irq_en_wr) r_irq_en <= irq_en_data;
      if (w_accept) begin
        r_epc   <= pc_id;
        r_cause <= w_win;
      end
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    RegWrite_out      = wb_regwrite;
    RegWrite_Reg_out  = wb_reg;
    RegWrite_Data_out = wb_data;
    flush             = 1'b0;
    pc_redirect       = 1'b0;
    pc_redirect_addr  = '0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = DRAIN;
          w_cnt_nxt   = CW'(DRAIN_CYCLES - 1);
        end
      end
      DRAIN: begin
        flush = 1'b1;
        if (r_cnt == '0) w_state_nxt = SAVE;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      SAVE: begin
        flush = 1'b1;
        // WB keeps priority on the write port; EPC waits for an idle slot.
        if (!wb_regwrite) begin
          RegWrite_out      = 1'b1;
          RegWrite_Reg_out  = EPC_REG;
          RegWrite_Data_out = r_epc;
          w_state_nxt       = VECTOR;
        end
      end
      VECTOR: begin
        flush            = 1'b1;
        pc_redirect      = 1'b1;
        pc_redirect_addr = VEC_BASE + 32'(r_cause) * 32'(VEC_STRIDE);
        w_state_nxt      = HANDLER;
      end
      HANDLER: begin
        if (intr_return) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign intr_active = (r_state != IDLE);
  assign intr_cause  = intr_active ? r_cause : 3'd0;

endmodule

// File: tb/tb_intr_controller.sv
// Randomized bench for intr_controller with a reference model that tracks the
// sequence as a cycle age since acceptance plus a handler flag.
module tb_intr_controller;

  localparam int D = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  irq = '0;
  logic        irq_en_wr = 1'b0;
  logic [3:0]  irq_en_data = '0;
  logic        data_hazard = 1'b0;
  logic        intr_return = 1'b0;
  logic [31:0] pc_id = '0;
  logic        wb_regwrite = 1'b0;
  logic [4:0]  wb_reg = '0;
  logic [31:0] wb_data = '0;
  logic        RegWrite_out;
  logic [4:0]  RegWrite_Reg_out;
  logic [31:0] RegWrite_Data_out;
  logic        flush;
  logic        pc_redirect;
  logic [31:0] pc_redirect_addr;
  logic        intr_active;
  logic [2:0]  intr_cause;
  logic [3:0]  irq_en;

  intr_controller dut (
    .clk(clk), .rst(rst), .irq(irq),
    .irq_en_wr(irq_en_wr), .irq_en_data(irq_en_data),
    .data_hazard(data_hazard), .intr_return(intr_return),
    .pc_id(pc_id), .wb_regwrite(wb_regwrite),
    .wb_reg(wb_reg), .wb_data(wb_data),
    .RegWrite_out(RegWrite_out),
    .RegWrite_Reg_out(RegWrite_Reg_out),
    .RegWrite_Data_out(RegWrite_Data_out),
    .flush(flush), .pc_redirect(pc_redirect),
    .pc_redirect_addr(pc_redirect_addr),
    .intr_active(intr_active), .intr_cause(intr_cause),
    .irq_en(irq_en)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  // Model: age 0 = no sequence, 1..D drain, D+1 save, D+2 vector.
  int          m_age;
  bit          m_hnd;
  logic [3:0]  m_en;
  logic [31:0] m_epc;
  int          m_cause;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_age = 0; m_hnd = 0; m_en = '0; m_epc = '0; m_cause = 0;
  endtask

  task automatic check_outputs();
    bit busy, save, vec;
    bit        e_we;
    logic [4:0]  e_reg;
    logic [31:0] e_dat;
    busy  = (m_age != 0) || m_hnd;
    save  = (m_age == D + 1);
    vec   = (m_age == D + 2);
    e_we  = wb_regwrite;
    e_reg = wb_reg;
    e_dat = wb_data;
    if (save && !wb_regwrite) begin
      e_we = 1'b1; e_reg = 5'h1E; e_dat = m_epc;
    end
    chk("we", 32'(RegWrite_out), 32'(e_we));
    chk("wreg", 32'(RegWrite_Reg_out), 32'(e_reg));
    chk("wdata", RegWrite_Data_out, e_dat);
    chk("flush", 32'(flush), 32'(m_age != 0));
    chk("redir", 32'(pc_redirect), 32'(vec));
    chk("raddr", pc_redirect_addr,
        vec ? 32'h100 + 32'(m_cause) * 4 : 32'h0);
    chk("active", 32'(intr_active), 32'(busy));
    chk("cause", 32'(intr_cause), busy ? 32'(m_cause) : 32'h0);
    chk("irq_en", 32'(irq_en), 32'(m_en));
  endtask

  task automatic model_update();
    logic [3:0] pend;
    pend = irq & m_en;
    if (irq_en_wr) m_en = irq_en_data;
    if (m_hnd) begin
      if (intr_return) m_hnd = 0;
    end else if (m_age == 0) begin
      if (pend != 0 && !data_hazard) begin
        m_epc = pc_id; m_cause = lowest(pend); m_age = 1;
      end
    end else if (m_age <= D) begin
      m_age++;
    end else if (m_age == D + 1) begin
      if (!wb_regwrite) m_age++;
    end else begin
      m_age = 0; m_hnd = 1;
    end
  endtask

  // Called right after a negedge with inputs already driven.
  task automatic cyc();
    #1;
    check_outputs();
    @(posedge clk);
    if (!rst) model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_en(input logic [3:0] m);
    irq_en_wr = 1'b1; irq_en_data = m;
    cyc();
    irq_en_wr = 1'b0;
  endtask

  task automatic finish_handler();
    irq = '0;
    repeat (2) cyc();
    intr_return = 1'b1;
    cyc();
    intr_return = 1'b0;
    cyc();
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // Single request, cause 0, PC 0x40.
    set_en(4'b0001);
    irq = 4'b0001; pc_id = 32'h40;
    repeat (7) cyc();
    finish_handler();

    // Two requests, lowest enabled wins.
    set_en(4'b1111);
    irq = 4'b1010; pc_id = 32'h80;
    repeat (7) cyc();
    finish_handler();

    // WB owns the port for two SAVE cycles.
    irq = 4'b0100; pc_id = 32'h1234;
    cyc();
    irq = '0;
    repeat (D) cyc();
    wb_regwrite = 1'b1; wb_reg = 5'd5; wb_data = 32'd7;
    repeat (2) cyc();
    wb_regwrite = 1'b0;
    repeat (3) cyc();

    // Return and new request together in HANDLER.
    irq = 4'b0001;
    repeat (2) cyc();
    intr_return = 1'b1;
    cyc();
    intr_return = 1'b0;
    repeat (8) cyc();
    finish_handler();

    // Hazard holds off acceptance; EPC comes from the accepting cycle.
    irq = 4'b0010; data_hazard = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc_id = 32'h200 + 32'(i) * 4;
      cyc();
    end
    data_hazard = 1'b0; pc_id = 32'h300;
    cyc();
    irq = '0;
    repeat (6) cyc();
    finish_handler();

    // Reset during DRAIN.
    irq = 4'b1000; pc_id = 32'h500;
    repeat (2) cyc();
    do_reset();
    irq = '0;
    repeat (3) cyc();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(299) == 0) begin
        do_reset();
      end else begin
        irq         = ($urandom_range(2) == 0) ? 4'($urandom) : 4'b0;
        irq_en_wr   = ($urandom_range(9) == 0);
        irq_en_data = 4'($urandom);
        data_hazard = ($urandom_range(2) == 0);
        intr_return = ($urandom_range(5) == 0);
        pc_id       = $urandom;
        wb_regwrite = $urandom_range(1);
        wb_reg      = 5'($urandom);
        wb_data     = $urandom;
        cyc();
      end
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
